// File: rtl/lab_pkg.sv
// Shared types and constants for the lab board input-conditioning blocks.
package lab_pkg;

  localparam int DEBOUNCE_SYNC_STAGES = 2;

  typedef logic [0:0] debounce_state_t;
  localparam debounce_state_t IDLE    = 1'b0;
  localparam debounce_state_t PENDING = 1'b1;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, IDLE/PENDING stability FSM and optional
// registered rise/fall pulses (enabled by SWITCH_EDGE_EN).
module debounce_bit
  import lab_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean
`ifdef SWITCH_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STABLE_CYCLES - 1);

  logic [DEBOUNCE_SYNC_STAGES-1:0] sync_chain;
  logic                            sync2;
  debounce_state_t                 state;
  debounce_state_t                 state_nx;
  logic [CNT_W-1:0]                cnt;
  logic [CNT_W-1:0]                cnt_nx;
  logic                            clean_nx;

  assign sync2 = sync_chain[DEBOUNCE_SYNC_STAGES-1];

  // Next-state logic: a level must differ from clean for STABLE_CYCLES edges in a row.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clean_nx = clean;
    case (state)
      IDLE: begin
        if (sync2 != clean) begin
          state_nx = PENDING;
          cnt_nx   = CNT_W'(1);
        end else begin
          cnt_nx   = {CNT_W{1'b0}};
        end
      end
      PENDING: begin
        if (sync2 == clean) begin
          state_nx = IDLE;
          cnt_nx   = {CNT_W{1'b0}};
        end else if (cnt == TERMINAL) begin
          clean_nx = sync2;
          state_nx = IDLE;
          cnt_nx   = {CNT_W{1'b0}};
        end else begin
          cnt_nx   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Synchroniser, FSM state, counter and clean level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain <= {DEBOUNCE_SYNC_STAGES{1'b0}};
      state      <= IDLE;
      cnt        <= {CNT_W{1'b0}};
      clean      <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[DEBOUNCE_SYNC_STAGES-2:0], raw};
      state      <= state_nx;
      cnt        <= cnt_nx;
      clean      <= clean_nx;
    end
  end

`ifdef SWITCH_EDGE_EN
  // Pulses line up with the first cycle clean shows its new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= clean_nx & ~clean;
      fall <= ~clean_nx & clean;
    end
  end
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Debounced slide-switch bus; per-bit rise/fall pulse ports exist only when
// SWITCH_EDGE_EN is defined.
module switch_debouncer
  import lab_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] switch_clean
`ifdef SWITCH_EDGE_EN
  ,
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall
`endif
);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > (1 << 20)) begin : g_bad_stable
    $error("switch_debouncer: STABLE_CYCLES must be in 2..2**20");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .raw  (switch[i]),
      .clean(switch_clean[i])
`ifdef SWITCH_EDGE_EN
      ,
      .rise (switch_rise[i]),
      .fall (switch_fall[i])
`endif
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with STABLE_CYCLES=4; edge pulses are checked
// when SWITCH_EDGE_EN is defined.
module tb_switch_debouncer;

  localparam int W = 8;
  localparam int S = 4;

  typedef struct {
    logic         rst;
    logic [W-1:0] sw;
    int           n;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  typedef struct {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] switch = 8'h00;
  logic [W-1:0] switch_clean;
`ifdef SWITCH_EDGE_EN
  logic [W-1:0] switch_rise;
  logic [W-1:0] switch_fall;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t tbl[$];

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .switch      (switch),
    .switch_clean(switch_clean)
`ifdef SWITCH_EDGE_EN
    ,
    .switch_rise (switch_rise),
    .switch_fall (switch_fall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    exp_t e;
    e = sb.pop_front();
    n_checks++;
    if (switch_clean !== e.clean) begin
      n_fail++;
      $display("FAIL %s clean: got %h want %h", tag, switch_clean, e.clean);
    end
`ifdef SWITCH_EDGE_EN
    n_checks++;
    if (switch_rise !== e.rise) begin
      n_fail++;
      $display("FAIL %s rise: got %h want %h", tag, switch_rise, e.rise);
    end
    n_checks++;
    if (switch_fall !== e.fall) begin
      n_fail++;
      $display("FAIL %s fall: got %h want %h", tag, switch_fall, e.fall);
    end
`endif
  endtask

  task automatic step(input logic r, input logic [W-1:0] s, input int n,
                      input logic [W-1:0] ec, input logic [W-1:0] er,
                      input logic [W-1:0] ef, input string tag);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst    = r;
      switch = s;
      e.clean = ec;
      e.rise  = er;
      e.fall  = ef;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", tag, k));
    end
  endtask

  initial begin
    // Reset with switches high, then the held-through-reset rise and a return to 0.
    tbl.push_back('{1'b1, 8'hFF, 3, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'hFF, 5, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'hFF, 1, 8'hFF, 8'hFF, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 5, 8'hFF, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 1, 8'h00, 8'h00, 8'hFF});
    tbl.push_back('{1'b0, 8'h00, 2, 8'h00, 8'h00, 8'h00});
    // Clean rise on bit 0, then back to 0.
    tbl.push_back('{1'b0, 8'h01, 5, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'h01, 1, 8'h01, 8'h01, 8'h00});
    tbl.push_back('{1'b0, 8'h01, 3, 8'h01, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 5, 8'h01, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 1, 8'h00, 8'h00, 8'h01});
    tbl.push_back('{1'b0, 8'h00, 2, 8'h00, 8'h00, 8'h00});
    // Bit 2 high for S-1 edges is the longest pulse that must be rejected.
    tbl.push_back('{1'b0, 8'h04, 3, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 6, 8'h00, 8'h00, 8'h00});
    // Simultaneous opposite changes: 0F then F0 then 00.
    tbl.push_back('{1'b0, 8'h0F, 5, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'h0F, 1, 8'h0F, 8'h0F, 8'h00});
    tbl.push_back('{1'b0, 8'h0F, 2, 8'h0F, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'hF0, 5, 8'h0F, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'hF0, 1, 8'hF0, 8'hF0, 8'h0F});
    tbl.push_back('{1'b0, 8'hF0, 2, 8'hF0, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 5, 8'hF0, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 1, 8'h00, 8'h00, 8'hF0});
    tbl.push_back('{1'b0, 8'h00, 2, 8'h00, 8'h00, 8'h00});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].sw, tbl[i].n, tbl[i].clean, tbl[i].rise,
           tbl[i].fall, $sformatf("vec%0d", i));
    end

    // Bounce on bit 7, then settle high: accepted 6 edges after the last 0->1.
    step(1'b0, 8'h80, 1, 8'h00, 8'h00, 8'h00, "bounce_a");
    step(1'b0, 8'h00, 1, 8'h00, 8'h00, 8'h00, "bounce_b");
    step(1'b0, 8'h80, 1, 8'h00, 8'h00, 8'h00, "bounce_c");
    step(1'b0, 8'h00, 1, 8'h00, 8'h00, 8'h00, "bounce_d");
    step(1'b0, 8'h80, 5, 8'h00, 8'h00, 8'h00, "settle_wait");
    step(1'b0, 8'h80, 1, 8'h80, 8'h80, 8'h00, "settle_rise");
    step(1'b0, 8'h80, 2, 8'h80, 8'h00, 8'h00, "settle_hold");
    step(1'b0, 8'h00, 5, 8'h80, 8'h00, 8'h00, "b7_fall_wait");
    step(1'b0, 8'h00, 1, 8'h00, 8'h00, 8'h80, "b7_fall");
    step(1'b0, 8'h00, 2, 8'h00, 8'h00, 8'h00, "b7_idle");

    // Reset at edge 3 of a pending rise discards it; restart after deassert.
    step(1'b0, 8'h01, 3, 8'h00, 8'h00, 8'h00, "midrst_pend");
    step(1'b1, 8'h01, 1, 8'h00, 8'h00, 8'h00, "midrst_rst");
    step(1'b0, 8'h01, 5, 8'h00, 8'h00, 8'h00, "midrst_wait");
    step(1'b0, 8'h01, 1, 8'h01, 8'h01, 8'h00, "midrst_rise");
    step(1'b0, 8'h01, 2, 8'h01, 8'h00, 8'h00, "midrst_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
